fractal_sync_req_fifo: RTL and testbench

- Per-input-port request buffer that sits directly upstream of the fractal synchronization request arbiter.
- Accepts fsync requests from a child node or local port and stores them in order.
- Presents the head element first-word-fall-through together with an empty flag, and dequeues on the arbiter's pop.
- One instance per arbiter input port.

---
 rtl/fractal_sync_req_fifo.sv | 95 +++++++++
 tb/tb_fractal_sync_req_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_req_fifo.sv
`default_nettype none
// ============================================================================
// fractal_sync_req_fifo : FWFT request buffer ahead of one fsync arbiter input
// Revision 1.0
// ============================================================================
module fractal_sync_req_fifo #(
  parameter int unsigned DEPTH       = 4,
  parameter type         fsync_req_t = logic,
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  fsync_req_t       element_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output fsync_req_t       element_o,
  output logic [CNT_W-1:0] usage_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fsync_req_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push_acc, pop_acc;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == FULL_CNT);
  assign usage_o     = count_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
  assign element_o   = empty_o ? fsync_req_t'('0) : mem_q[rd_ptr_q];

  // Full gates the push even when a pop frees a slot in the same cycle.
  assign push_acc = push_i & ~full_o & ~flush_i;
  assign pop_acc  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop_acc)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (push_i && full_o)  overflow_d  = 1'b1;
      if (pop_i && empty_o)  underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_acc) mem_q[wr_ptr_q] <= element_i;
  end

endmodule
`default_nettype wire

// File: tb/tb_fractal_sync_req_fifo.sv
`default_nettype none
// ============================================================================
// tb_fractal_sync_req_fifo : directed vector bench for fractal_sync_req_fifo
// Revision 1.0
// ============================================================================
module tb_fractal_sync_req_fifo;

  localparam int unsigned DEPTH = 4;
  typedef logic [7:0] req_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       push = 1'b0;
  req_t       din = '0;
  logic       pop = 1'b0;
  logic       full, empty, ovf, udf;
  req_t       dout;
  logic [2:0] usage;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       push;
    req_t       din;
    logic       pop;
    logic       flush;
    logic       e_empty;
    logic       e_full;
    logic [2:0] e_usage;
    req_t       e_elem;
    logic       e_ovf;
    logic       e_udf;
  } vec_t;

  vec_t tbl[$];
  req_t model_q[$];
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;

  fractal_sync_req_fifo #(
    .DEPTH      (DEPTH),
    .fsync_req_t(req_t)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .push_i     (push),
    .element_i  (din),
    .full_o     (full),
    .pop_i      (pop),
    .empty_o    (empty),
    .element_o  (dout),
    .usage_o    (usage),
    .overflow_o (ovf),
    .underflow_o(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_empty, input logic e_full,
                           input logic [2:0] e_usage, input req_t e_elem,
                           input logic e_ovf, input logic e_udf);
    chk({tag, ".empty"}, 32'(empty), 32'(e_empty));
    chk({tag, ".full"},  32'(full),  32'(e_full));
    chk({tag, ".usage"}, 32'(usage), 32'(e_usage));
    chk({tag, ".elem"},  32'(dout),  32'(e_elem));
    chk({tag, ".ovf"},   32'(ovf),   32'(e_ovf));
    chk({tag, ".udf"},   32'(udf),   32'(e_udf));
  endtask

  // Queue-based reference for the multi-cycle sequences.
  task automatic step(input logic p, input req_t d, input logic po, input logic fl,
                      input string tag);
    logic was_full, was_empty;
    push = p; din = d; pop = po; flush = fl;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (fl) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (p && was_full)  m_ovf = 1'b1;
      if (po && was_empty) m_udf = 1'b1;
      if (po && !was_empty) void'(model_q.pop_front());
      if (p && !was_full) model_q.push_back(d);
    end
    check_all(tag, model_q.size() == 0, model_q.size() == DEPTH,
              3'(model_q.size()), (model_q.size() == 0) ? req_t'(0) : model_q[0],
              m_ovf, m_udf);
  endtask

  initial begin
    // push, din, pop, flush | empty, full, usage, elem, ovf, udf
    tbl.push_back('{1, 8'h0A, 0, 0, 0, 0, 3'd1, 8'h0A, 0, 0});
    tbl.push_back('{1, 8'h0B, 0, 0, 0, 0, 3'd2, 8'h0A, 0, 0});
    tbl.push_back('{1, 8'h0C, 0, 0, 0, 0, 3'd3, 8'h0A, 0, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 3'd2, 8'h0B, 0, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 3'd1, 8'h0C, 0, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 1, 0, 3'd0, 8'h00, 0, 0});
    tbl.push_back('{1, 8'h01, 0, 0, 0, 0, 3'd1, 8'h01, 0, 0});
    tbl.push_back('{1, 8'h02, 0, 0, 0, 0, 3'd2, 8'h01, 0, 0});
    tbl.push_back('{1, 8'h03, 0, 0, 0, 0, 3'd3, 8'h01, 0, 0});
    tbl.push_back('{1, 8'h04, 0, 0, 0, 1, 3'd4, 8'h01, 0, 0});
    tbl.push_back('{1, 8'h05, 0, 0, 0, 1, 3'd4, 8'h01, 1, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 3'd3, 8'h02, 1, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 3'd2, 8'h03, 1, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 3'd1, 8'h04, 1, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 1, 0, 3'd0, 8'h00, 1, 0});
    tbl.push_back('{0, 8'h00, 0, 1, 1, 0, 3'd0, 8'h00, 0, 0});
    tbl.push_back('{1, 8'h11, 0, 0, 0, 0, 3'd1, 8'h11, 0, 0});
    tbl.push_back('{1, 8'h12, 0, 0, 0, 0, 3'd2, 8'h11, 0, 0});
    tbl.push_back('{1, 8'h13, 0, 0, 0, 0, 3'd3, 8'h11, 0, 0});
    tbl.push_back('{1, 8'h14, 0, 0, 0, 1, 3'd4, 8'h11, 0, 0});
    tbl.push_back('{1, 8'h09, 1, 0, 0, 0, 3'd3, 8'h12, 1, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 3'd2, 8'h13, 1, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 3'd1, 8'h14, 1, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 1, 0, 3'd0, 8'h00, 1, 0});
    tbl.push_back('{1, 8'h07, 1, 0, 0, 0, 3'd1, 8'h07, 1, 1});
    tbl.push_back('{0, 8'h00, 1, 0, 1, 0, 3'd0, 8'h00, 1, 1});
    tbl.push_back('{1, 8'h21, 0, 0, 0, 0, 3'd1, 8'h21, 1, 1});
    tbl.push_back('{1, 8'h22, 0, 0, 0, 0, 3'd2, 8'h21, 1, 1});
    tbl.push_back('{1, 8'h23, 0, 0, 0, 0, 3'd3, 8'h21, 1, 1});
    tbl.push_back('{1, 8'h24, 0, 1, 1, 0, 3'd0, 8'h00, 0, 0});
    tbl.push_back('{0, 8'h00, 0, 0, 1, 0, 3'd0, 8'h00, 0, 0});

    #2;
    check_all("reset", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    #5 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      push = tbl[i].push; din = tbl[i].din; pop = tbl[i].pop; flush = tbl[i].flush;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; flush = 1'b0;
      check_all($sformatf("vec%0d", i), tbl[i].e_empty, tbl[i].e_full, tbl[i].e_usage,
                tbl[i].e_elem, tbl[i].e_ovf, tbl[i].e_udf);
    end

    // Pointer wrap: ordering must survive several trips around the ring.
    step(1, 8'h40, 0, 0, "wrap_seed");
    for (int r = 0; r < 4; r++) begin
      step(1, req_t'(8'h50 + 3 * r), 0, 0, "wrap_push");
      step(1, req_t'(8'h51 + 3 * r), 0, 0, "wrap_push");
      step(0, 8'h00, 1, 0, "wrap_pop");
      step(0, 8'h00, 1, 0, "wrap_pop");
    end
    for (int k = 0; k < 6; k++) step(1, req_t'(8'h70 + k), 1, 0, "wrap_pp");
    step(0, 8'h00, 1, 0, "wrap_drain");

    // Async reset between edges with live entries and a sticky flag set.
    step(0, 8'h00, 1, 0, "ar_udf");
    step(1, 8'h31, 0, 0, "ar_fill");
    step(1, 8'h32, 0, 0, "ar_fill");
    #3 rst = 1'b1;
    #1;
    check_all("async_rst", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b0;
    model_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    step(1, 8'h05, 0, 0, "post_rst");
    chk("post_rst.head", 32'(dout), 32'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
